// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and constants for the two-port SDRAM arbiter
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam logic       PORT_DISP = 1'b0;
    localparam logic       PORT_GFX  = 1'b1;
    localparam logic [1:0] SEL_ALL   = 2'b11;

endpackage

// File: rtl/sdram_arb_select.sv
// rtl/sdram_arb_select.sv - winner selection with optional starve counter (SDRAM_ARB_ANTI_STARVE_EN)
module sdram_arb_select
    import sdram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic p0_req,
    input  logic p1_req,
    input  logic grant_evt,
    input  logic grant_port,
    output logic winner
);

`ifdef SDRAM_ARB_ANTI_STARVE_EN
    localparam int CNT_RAW = $clog2(STARVE_LIMIT + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    // Count display grants that left the rasterizer waiting; saturates at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant_evt) begin
            if (grant_port == PORT_GFX || !p1_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    assign starved = (starve_cnt == LIMIT);

    // Display wins unless it is idle or the rasterizer has waited long enough
    always_comb begin
        winner = PORT_DISP;
        if (!p0_req) begin
            winner = PORT_GFX;
        end else if (p1_req && starved) begin
            winner = PORT_GFX;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, grant_evt, grant_port, p1_req, (STARVE_LIMIT != 0)};

    // Strict priority: display always wins when it requests
    always_comb begin
        winner = p0_req ? PORT_DISP : PORT_GFX;
    end
`endif

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-port arbiter/sequencer for the SDRAM controller, optional SDRAM_ARB_ANTI_STARVE_EN
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W       = 24,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n_i,
    input  logic              p0_req_i,
    input  logic [ADDR_W-1:0] p0_adr_i,
    output logic [15:0]       p0_dat_o,
    output logic              p0_ack_o,
    input  logic              p1_req_i,
    input  logic              p1_we_i,
    input  logic [ADDR_W-1:0] p1_adr_i,
    input  logic [15:0]       p1_dat_i,
    input  logic [1:0]        p1_sel_i,
    output logic [15:0]       p1_dat_o,
    output logic              p1_ack_o,
    input  logic              mem_idle_i,
    output logic              mem_acc_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_adr_o,
    output logic [15:0]       mem_dat_o,
    output logic [1:0]        mem_sel_o,
    input  logic [15:0]       mem_dat_i,
    input  logic              mem_ack_i
);

    arb_state_t state;
    arb_state_t state_next;
    logic       grant;
    logic       grant_evt;
    logic       winner;
    logic       mem_done;

    sdram_arb_select #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_select (
        .clk       (clk),
        .rst_n     (reset_n_i),
        .p0_req    (p0_req_i),
        .p1_req    (p1_req_i),
        .grant_evt (grant_evt),
        .grant_port(winner),
        .winner    (winner)
    );

    assign mem_done = (state == BUSY) && mem_ack_i;

    // State register
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; RELEASE is a dead cycle so a just-acked requester cannot be re-granted
    always_comb begin
        state_next = state;
        grant_evt  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_idle_i && (p0_req_i || p1_req_i)) begin
                    grant_evt  = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Controller-side request registers: loaded at grant, held through BUSY
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            grant     <= PORT_DISP;
            mem_acc_o <= 1'b0;
            mem_we_o  <= 1'b0;
            mem_adr_o <= '0;
            mem_dat_o <= '0;
            mem_sel_o <= SEL_ALL;
        end else if (grant_evt) begin
            grant     <= winner;
            mem_acc_o <= 1'b1;
            if (winner == PORT_DISP) begin
                mem_we_o  <= 1'b0;
                mem_adr_o <= 32'(p0_adr_i);
                mem_dat_o <= '0;
                mem_sel_o <= SEL_ALL;
            end else begin
                mem_we_o  <= p1_we_i;
                mem_adr_o <= 32'(p1_adr_i);
                mem_dat_o <= p1_dat_i;
                mem_sel_o <= p1_we_i ? p1_sel_i : SEL_ALL;
            end
        end else if (mem_done) begin
            mem_acc_o <= 1'b0;
            mem_we_o  <= 1'b0;
        end
    end

    // Client-side completion: one-cycle ack, read data captured only for reads
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            p0_ack_o <= 1'b0;
            p1_ack_o <= 1'b0;
            p0_dat_o <= '0;
            p1_dat_o <= '0;
        end else begin
            p0_ack_o <= 1'b0;
            p1_ack_o <= 1'b0;
            if (mem_done) begin
                if (grant == PORT_DISP) begin
                    p0_ack_o <= 1'b1;
                    p0_dat_o <= mem_dat_i;
                end else begin
                    p1_ack_o <= 1'b1;
                    if (!mem_we_o) begin
                        p1_dat_o <= mem_dat_i;
                    end
                end
            end
        end
    end

endmodule
